// File: rtl/mem_arbiter.sv
// Shares one off-chip memory port between I-cache refills and D-cache refill/write-back.
// D-first arbitration with a bounded D streak; one registered transaction outstanding at a time.
module mem_arbiter #(
   parameter int unsigned ADDR_W   = 28,
   parameter int unsigned LINE_W   = 128,
   parameter int unsigned D_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              mem_busy
);

   localparam int unsigned STREAK_W = $clog2(D_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_STREAK);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [STREAK_W-1:0] streak;
   logic                d_any_c;
   logic                grant_i_c;
   logic                grant_d_c;
   logic                done_i_c;
   logic                done_d_c;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arbitration and completion decode; RESP never arbitrates so requesters can drop
   always_comb begin
      state_nxt = state;
      grant_i_c = 1'b0;
      grant_d_c = 1'b0;
      done_i_c  = 1'b0;
      done_d_c  = 1'b0;
      d_any_c   = d_read | d_write;
      case (state)
         IDLE: begin
            if (i_req && (!d_any_c || (streak == STREAK_MAX))) begin
               grant_i_c = 1'b1;
               state_nxt = SERVE_I;
            end else if (d_any_c) begin
               grant_d_c = 1'b1;
               state_nxt = SERVE_D;
            end
         end
         SERVE_I: begin
            if (mem_ready) begin
               done_i_c  = 1'b1;
               state_nxt = RESP;
            end
         end
         SERVE_D: begin
            if (mem_ready) begin
               done_d_c  = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch, response capture and streak tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak    <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_busy  <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
      end else begin
         mem_busy <= (state_nxt != IDLE);
         i_ready  <= done_i_c;
         d_ready  <= done_d_c;
         if (grant_i_c) begin
            mem_addr  <= i_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            streak    <= '0;
         end
         if (grant_d_c) begin
            // a simultaneous read+write from D is treated as a write
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_read  <= ~d_write;
            mem_write <= d_write;
            streak    <= i_req ? (streak + STREAK_W'(1)) : '0;
         end
         if (done_i_c || done_d_c) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
         if (done_i_c) begin
            i_rdata <= mem_rdata;
         end
         if (done_d_c) begin
            d_rdata <= mem_rdata;
         end
      end
   end

endmodule
